// File: rtl/scan_mux_n_to_1.sv
// scan_mux_n_to_1
// Registered N-channel, W-bit multiplexer with two selection modes:
//   manual : the channel comes from sel; an out-of-range sel is flagged and dropped
//   scan   : an internal pointer visits every channel round-robin, DWELL enabled
//            cycles per channel
// Every accepted sample comes out one cycle later, tagged with its source channel.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   data_in  in   CHANNELS*WIDTH packed channels, channel k at [k*WIDTH +: WIDTH]
//   en       in   sample enable; pointer, dwell count and outputs freeze when low
//   mode     in   0 = manual select, 1 = round-robin scan
//   sel      in   manual channel select (ignored in scan mode)
//   data_out out  registered selected data
//   ch_out   out  channel index that produced data_out
//   valid    out  one-cycle strobe per accepted sample
//   wrap     out  pulse with the last dwell sample of channel CHANNELS-1
//   sel_err  out  pulse when a manual select is out of range
module scan_mux_n_to_1 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2,
    parameter int DWELL    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    output logic [WIDTH-1:0]          data_out,
    output logic [SEL_W-1:0]          ch_out,
    output logic                      valid,
    output logic                      wrap,
    output logic                      sel_err
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(CHANNELS - 1);

    logic [SEL_W-1:0] ptr;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] sel_data;
    logic             sel_ok;

    // One extra bit so the compare also works when 2**SEL_W == CHANNELS.
    assign sel_ok = ({1'b0, sel} < (SEL_W + 1)'(CHANNELS));
    assign idx    = mode ? ptr : sel;

    // Decoded mux. An index with no matching channel gives zero, but that value
    // is never registered because out-of-range selects are not accepted.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (idx == SEL_W'(k)) begin
                sel_data = data_in[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out <= '0;
            ch_out   <= '0;
            valid    <= 1'b0;
            wrap     <= 1'b0;
            sel_err  <= 1'b0;
            ptr      <= '0;
            cnt      <= '0;
        end else begin
            valid   <= 1'b0;
            wrap    <= 1'b0;
            sel_err <= 1'b0;
            if (en) begin
                if (!mode) begin
                    // Keeping the scan state cleared here makes every entry into
                    // scan start on channel 0 with a full dwell.
                    ptr <= '0;
                    cnt <= '0;
                    if (sel_ok) begin
                        data_out <= sel_data;
                        ch_out   <= sel;
                        valid    <= 1'b1;
                    end else begin
                        sel_err <= 1'b1;
                    end
                end else begin
                    data_out <= sel_data;
                    ch_out   <= ptr;
                    valid    <= 1'b1;
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (ptr == PTR_LAST) begin
                            ptr  <= '0;
                            wrap <= 1'b1;
                        end else begin
                            ptr <= ptr + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_scan_mux_n_to_1.sv
module tb_scan_mux_n_to_1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Four-channel instance, DWELL=2
    logic [31:0] din4;
    logic        en4, mode4;
    logic [1:0]  sel4;
    logic [7:0]  dout4;
    logic [1:0]  ch4;
    logic        valid4, wrap4, err4;

    // Three-channel instance, DWELL=2
    logic [23:0] din3;
    logic        en3, mode3;
    logic [1:0]  sel3;
    logic [7:0]  dout3;
    logic [1:0]  ch3;
    logic        valid3, wrap3, err3;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] chv [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};

    scan_mux_n_to_1 #(.WIDTH(8), .CHANNELS(4), .SEL_W(2), .DWELL(2)) dut4 (
        .clk(clk), .rst(rst), .data_in(din4), .en(en4), .mode(mode4), .sel(sel4),
        .data_out(dout4), .ch_out(ch4), .valid(valid4), .wrap(wrap4), .sel_err(err4)
    );

    scan_mux_n_to_1 #(.WIDTH(8), .CHANNELS(3), .SEL_W(2), .DWELL(2)) dut3 (
        .clk(clk), .rst(rst), .data_in(din3), .en(en3), .mode(mode3), .sel(sel3),
        .data_out(dout3), .ch_out(ch3), .valid(valid3), .wrap(wrap3), .sel_err(err3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en4 = 1'b0; mode4 = 1'b0; sel4 = 2'd0;
        en3 = 1'b0; mode3 = 1'b0; sel3 = 2'd0;
        repeat (3) tick();
        n_cmp++; if (dout4 !== 8'h00) begin n_err++; $display("FAIL rst_data4: got %h want 00", dout4); end
        n_cmp++; if (ch4 !== 2'd0) begin n_err++; $display("FAIL rst_ch4: got %0d want 0", ch4); end
        n_cmp++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL rst_valid4: got %b want 0", valid4); end
        n_cmp++; if (wrap4 !== 1'b0) begin n_err++; $display("FAIL rst_wrap4: got %b want 0", wrap4); end
        n_cmp++; if (err4 !== 1'b0) begin n_err++; $display("FAIL rst_selerr4: got %b want 0", err4); end
        n_cmp++; if (dout3 !== 8'h00 || valid3 !== 1'b0) begin n_err++; $display("FAIL rst_dut3: got %h/%b want 00/0", dout3, valid3); end
        rst = 1'b0;
        repeat (2) tick();
        n_cmp++; if (dout4 !== 8'h00) begin n_err++; $display("FAIL idle_data4: got %h want 00", dout4); end
        n_cmp++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL idle_valid4: got %b want 0", valid4); end
        n_cmp++; if (ch4 !== 2'd0) begin n_err++; $display("FAIL idle_ch4: got %0d want 0", ch4); end
    endtask

    task automatic test_manual();
        en4 = 1'b1; mode4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel4 = 2'(i);
            tick();
            n_cmp++; if (dout4 !== chv[i]) begin n_err++; $display("FAIL man_data sel=%0d: got %h want %h", i, dout4, chv[i]); end
            n_cmp++; if (ch4 !== 2'(i)) begin n_err++; $display("FAIL man_ch sel=%0d: got %0d want %0d", i, ch4, i); end
            n_cmp++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL man_valid sel=%0d: got %b want 1", i, valid4); end
            n_cmp++; if (err4 !== 1'b0) begin n_err++; $display("FAIL man_selerr sel=%0d: got %b want 0", i, err4); end
        end
    endtask

    task automatic test_scan();
        logic [7:0] exp_d [9] = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hC2, 8'hC2, 8'hD3, 8'hD3, 8'hA0};
        logic [1:0] exp_c [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        en4 = 1'b1; mode4 = 1'b1; sel4 = 2'd2;
        for (int i = 0; i < 9; i++) begin
            tick();
            n_cmp++; if (dout4 !== exp_d[i]) begin n_err++; $display("FAIL scan_data[%0d]: got %h want %h", i, dout4, exp_d[i]); end
            n_cmp++; if (ch4 !== exp_c[i]) begin n_err++; $display("FAIL scan_ch[%0d]: got %0d want %0d", i, ch4, exp_c[i]); end
            n_cmp++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL scan_valid[%0d]: got %b want 1", i, valid4); end
            n_cmp++; if (wrap4 !== (i == 7)) begin n_err++; $display("FAIL scan_wrap[%0d]: got %b want %b", i, wrap4, (i == 7)); end
        end
    endtask

    task automatic test_en_gap();
        logic [7:0] exp_d [5] = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hC2};
        // One manual cycle clears the scan state left over from the previous run.
        en4 = 1'b1; mode4 = 1'b0; sel4 = 2'd0;
        tick();
        mode4 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (dout4 !== exp_d[i]) begin n_err++; $display("FAIL gap_pre[%0d]: got %h want %h", i, dout4, exp_d[i]); end
        end
        en4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (dout4 !== 8'hB1) begin n_err++; $display("FAIL gap_hold[%0d]: got %h want b1", i, dout4); end
            n_cmp++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL gap_valid[%0d]: got %b want 0", i, valid4); end
            n_cmp++; if (ch4 !== 2'd1) begin n_err++; $display("FAIL gap_ch[%0d]: got %0d want 1", i, ch4); end
        end
        en4 = 1'b1;
        for (int i = 3; i < 5; i++) begin
            tick();
            n_cmp++; if (dout4 !== exp_d[i]) begin n_err++; $display("FAIL gap_post[%0d]: got %h want %h", i, dout4, exp_d[i]); end
            n_cmp++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL gap_post_valid[%0d]: got %b want 1", i, valid4); end
        end
    endtask

    task automatic test_three_channels();
        logic [1:0] exp_c [8] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
        logic [7:0] exp_d [8] = '{8'hA0, 8'hA0, 8'hB1, 8'hB1, 8'hC2, 8'hC2, 8'hA0, 8'hA0};
        en3 = 1'b1; mode3 = 1'b0; sel3 = 2'd1;
        tick();
        n_cmp++; if (dout3 !== 8'hB1 || valid3 !== 1'b1) begin n_err++; $display("FAIL c3_sel1: got %h/%b want b1/1", dout3, valid3); end
        sel3 = 2'd3;
        tick();
        n_cmp++; if (err3 !== 1'b1) begin n_err++; $display("FAIL c3_selerr: got %b want 1", err3); end
        n_cmp++; if (valid3 !== 1'b0) begin n_err++; $display("FAIL c3_oor_valid: got %b want 0", valid3); end
        n_cmp++; if (dout3 !== 8'hB1) begin n_err++; $display("FAIL c3_oor_hold: got %h want b1", dout3); end
        n_cmp++; if (ch3 !== 2'd1) begin n_err++; $display("FAIL c3_oor_ch: got %0d want 1", ch3); end
        sel3 = 2'd0;
        tick();
        n_cmp++; if (err3 !== 1'b0) begin n_err++; $display("FAIL c3_selerr_clear: got %b want 0", err3); end
        n_cmp++; if (dout3 !== 8'hA0) begin n_err++; $display("FAIL c3_sel0: got %h want a0", dout3); end
        mode3 = 1'b1; sel3 = 2'd3;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (ch3 !== exp_c[i]) begin n_err++; $display("FAIL c3_scan_ch[%0d]: got %0d want %0d", i, ch3, exp_c[i]); end
            n_cmp++; if (dout3 !== exp_d[i]) begin n_err++; $display("FAIL c3_scan_data[%0d]: got %h want %h", i, dout3, exp_d[i]); end
            n_cmp++; if (wrap3 !== (i == 5)) begin n_err++; $display("FAIL c3_scan_wrap[%0d]: got %b want %b", i, wrap3, (i == 5)); end
            n_cmp++; if (err3 !== 1'b0) begin n_err++; $display("FAIL c3_scan_selerr[%0d]: got %b want 0", i, err3); end
        end
        en3 = 1'b0;
    endtask

    task automatic test_async_reset();
        en4 = 1'b1; mode4 = 1'b0; sel4 = 2'd0;
        tick();
        mode4 = 1'b1;
        repeat (5) tick();
        n_cmp++; if (dout4 !== 8'hC2 || ch4 !== 2'd2) begin n_err++; $display("FAIL ar_pre: got %h/%0d want c2/2", dout4, ch4); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (dout4 !== 8'h00) begin n_err++; $display("FAIL ar_data: got %h want 00", dout4); end
        n_cmp++; if (ch4 !== 2'd0) begin n_err++; $display("FAIL ar_ch: got %0d want 0", ch4); end
        n_cmp++; if (valid4 !== 1'b0) begin n_err++; $display("FAIL ar_valid: got %b want 0", valid4); end
        tick();
        rst = 1'b0;
        tick();
        n_cmp++; if (dout4 !== 8'hA0 || ch4 !== 2'd0) begin n_err++; $display("FAIL ar_first: got %h/%0d want a0/0", dout4, ch4); end
        n_cmp++; if (valid4 !== 1'b1) begin n_err++; $display("FAIL ar_first_valid: got %b want 1", valid4); end
        tick();
        n_cmp++; if (dout4 !== 8'hA0) begin n_err++; $display("FAIL ar_dwell: got %h want a0", dout4); end
        tick();
        n_cmp++; if (dout4 !== 8'hB1) begin n_err++; $display("FAIL ar_next: got %h want b1", dout4); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        din4 = 32'hD3C2_B1A0;
        din3 = 24'hC2_B1A0;
        test_reset();
        test_manual();
        test_scan();
        test_en_gap();
        test_three_channels();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
